// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths and writeback request types
package rf_pkg;
   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = 5;
   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [XLEN-1:0] xlen_t;
   typedef struct packed {
      reg_addr_t addr;
      xlen_t     data;
   } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant among N requesters; round-robin, or fixed priority when WBARB_FIXED_PRIO_EN is defined
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] valid_i,
   output logic [N-1:0] grant_o
);
`ifdef WBARB_FIXED_PRIO_EN
   logic found;
   // lowest-index valid requester always wins
   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && valid_i[i]) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end
`else
   localparam int PW = $clog2(N);
   logic [PW-1:0] ptr_q, ptr_d;
   logic          found;
   int            idx;
   // search from the pointer, wrapping; pointer moves past the winner
   always_comb begin
      grant_o = '0;
      ptr_d   = ptr_q;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_q) + k) % N;
         if (!found && valid_i[idx]) begin
            grant_o[idx] = 1'b1;
            ptr_d        = PW'((idx + 1) % N);
            found        = 1'b1;
         end
      end
   end
   // pointer register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end
`endif
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the regfile write port among NREQ writeback requesters and tracks busy destinations
// Optional WBARB_FIXED_PRIO_EN selects fixed priority instead of round-robin (inside rr_arbiter).
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int XLEN = rf_pkg::XLEN,
   parameter int NREG = rf_pkg::NREG
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [REG_AW*NREQ-1:0]   req_addr,
   input  logic [XLEN*NREQ-1:0]     req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     rsv_valid,
   input  reg_addr_t                rsv_addr,
   output logic                     regwen,
   output reg_addr_t                waddr,
   output logic [XLEN-1:0]          wdata,
   output logic [NREG-1:0]          busy
);
   logic            regwen_q, regwen_d;
   reg_addr_t       waddr_q, waddr_d, sel_addr;
   logic [XLEN-1:0] wdata_q, wdata_d, sel_data;
   logic [NREG-1:0] busy_q, busy_d;
   logic            any;

   rr_arbiter #(.N(NREQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid_i (req_valid),
      .grant_o (req_ready)
   );

   // mux the granted request; x0 completes the handshake but never writes
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            sel_addr = sel_addr | req_addr[REG_AW*i +: REG_AW];
            sel_data = sel_data | req_data[XLEN*i +: XLEN];
         end
      end
      any      = |req_ready;
      regwen_d = any && (sel_addr != '0);
      waddr_d  = any ? sel_addr : waddr_q;
      wdata_d  = any ? sel_data : wdata_q;
   end

   // scoreboard: reserve sets, completed write clears, set wins, x0 never busy
   always_comb begin
      busy_d = '0;
      for (int r = 1; r < NREG; r++)
         busy_d[r] = (rsv_valid && rsv_addr == REG_AW'(r)) ||
                     (busy_q[r] && !(regwen_q && waddr_q == REG_AW'(r)));
   end

   // write-port and scoreboard registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regwen_q <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         busy_q   <= '0;
      end else begin
         regwen_q <= regwen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
      end
   end

   assign regwen = regwen_q;
   assign waddr  = waddr_q;
   assign wdata  = wdata_q;
   assign busy   = busy_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and randomized checks of rf_wb_arbiter against a behavioural model
module tb_rf_wb_arbiter;
   localparam int N  = 2;
   localparam int XL = 32;
   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [5*N-1:0]  req_addr = '0;
   logic [XL*N-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            rsv_valid = 1'b0;
   logic [4:0]      rsv_addr = '0;
   logic            regwen;
   logic [4:0]      waddr;
   logic [XL-1:0]   wdata;
   logic [31:0]     busy;
   int vec = 0;
   int errs = 0;
   int          m_ptr = 0;
   logic        m_regwen = 1'b0;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_busy = '0;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.NREQ(N), .XLEN(XL), .NREG(32)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .rsv_valid(rsv_valid),
      .rsv_addr(rsv_addr), .regwen(regwen), .waddr(waddr), .wdata(wdata),
      .busy(busy)
   );

   function automatic int exp_win(input logic [N-1:0] v);
`ifdef WBARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (v[i]) return i;
`else
      for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      int w;
      logic [N-1:0] g;
      w = exp_win(req_valid);
      g = '0;
      if (w >= 0) g[w] = 1'b1;
      return g;
   endfunction

   task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
      req_valid[i] = v;
      req_addr[5*i +: 5] = a;
      req_data[XL*i +: XL] = d;
   endtask

   task automatic cycle();
      int w;
      logic [31:0] nb;
      w = exp_win(req_valid);
      @(posedge clk);
      nb = m_busy;
      if (m_regwen) nb[m_waddr] = 1'b0;
      if (rsv_valid && rsv_addr != 0) nb[rsv_addr] = 1'b1;
      m_busy = nb;
      if (w >= 0) begin
         m_waddr  = req_addr[5*w +: 5];
         m_wdata  = req_data[XL*w +: XL];
         m_regwen = (m_waddr != 0);
         m_ptr    = (w + 1) % N;
      end else m_regwen = 1'b0;
      #1;
   endtask

   task automatic enter_reset();
      rst = 1'b0;
      m_ptr = 0; m_regwen = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0;
      #1;
   endtask

   task automatic leave_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      enter_reset();
      vec++; if (regwen !== 1'b0) begin errs++; $display("FAIL reset_regwen got %b want 0", regwen); end
      vec++; if (waddr !== 5'd0) begin errs++; $display("FAIL reset_waddr got %0d want 0", waddr); end
      vec++; if (wdata !== 32'd0) begin errs++; $display("FAIL reset_wdata got %h want 0", wdata); end
      vec++; if (busy !== 32'd0) begin errs++; $display("FAIL reset_busy got %h want 0", busy); end
      vec++; if (req_ready !== 2'b00) begin errs++; $display("FAIL reset_ready got %b want 00", req_ready); end
      leave_reset();
      cycle();
      vec++; if (regwen !== 1'b0) begin errs++; $display("FAIL reset_idle_regwen got %b want 0", regwen); end
   endtask

   task automatic test_reset_mid_write();
      set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
      rsv_valid = 1'b1; rsv_addr = 5'd5;
      #1;
      vec++; if (req_ready !== 2'b01) begin errs++; $display("FAIL midrst_ready got %b want 01", req_ready); end
      cycle();
      set_req(0, 1'b0, 5'd0, 32'd0);
      rsv_valid = 1'b0;
      vec++; if (regwen !== 1'b1 || waddr !== 5'd5) begin errs++; $display("FAIL midrst_pre got regwen=%b waddr=%0d want 1/5", regwen, waddr); end
      enter_reset();
      vec++; if (regwen !== 1'b0) begin errs++; $display("FAIL midrst_regwen got %b want 0", regwen); end
      vec++; if (busy !== 32'd0) begin errs++; $display("FAIL midrst_busy got %h want 0", busy); end
      leave_reset();
      cycle();
      vec++; if (regwen !== 1'b0) begin errs++; $display("FAIL midrst_idle got %b want 0", regwen); end
   endtask

   task automatic test_contention();
      set_req(0, 1'b1, 5'd1, $urandom);
      set_req(1, 1'b1, 5'd2, $urandom);
      for (int c = 0; c < 4; c++) begin
         #1;
         vec++; if (req_ready !== exp_ready()) begin errs++; $display("FAIL cont_ready[%0d] got %b want %b", c, req_ready, exp_ready()); end
`ifndef WBARB_FIXED_PRIO_EN
         vec++; if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin errs++; $display("FAIL cont_rr[%0d] got %b", c, req_ready); end
`endif
         cycle();
         vec++; if (regwen !== m_regwen || waddr !== m_waddr || wdata !== m_wdata) begin
            errs++; $display("FAIL cont_write[%0d] got %b/%0d/%h want %b/%0d/%h", c, regwen, waddr, wdata, m_regwen, m_waddr, m_wdata);
         end
      end
      set_req(0, 1'b0, 5'd0, 32'd0);
      set_req(1, 1'b0, 5'd0, 32'd0);
      cycle();
      vec++; if (regwen !== 1'b0 || waddr !== m_waddr) begin errs++; $display("FAIL cont_hold got %b/%0d want 0/%0d", regwen, waddr, m_waddr); end
   endtask

   task automatic test_x0();
      set_req(1, 1'b1, 5'd0, 32'h12345678);
      #1;
      vec++; if (req_ready !== 2'b10) begin errs++; $display("FAIL x0_ready got %b want 10", req_ready); end
      cycle();
      set_req(1, 1'b0, 5'd0, 32'd0);
      vec++; if (regwen !== 1'b0) begin errs++; $display("FAIL x0_regwen got %b want 0", regwen); end
   endtask

   task automatic test_scoreboard();
      rsv_valid = 1'b1; rsv_addr = 5'd7;
      cycle();
      rsv_valid = 1'b0;
      vec++; if (busy[7] !== 1'b1) begin errs++; $display("FAIL sb_set got %b want 1", busy[7]); end
      set_req(0, 1'b1, 5'd7, 32'hA5A5_0007);
      cycle();
      set_req(0, 1'b0, 5'd0, 32'd0);
      vec++; if (regwen !== 1'b1 || waddr !== 5'd7 || busy[7] !== 1'b1) begin
         errs++; $display("FAIL sb_write got %b/%0d/%b want 1/7/1", regwen, waddr, busy[7]);
      end
      cycle();
      vec++; if (busy[7] !== 1'b0) begin errs++; $display("FAIL sb_clear got %b want 0", busy[7]); end
      rsv_valid = 1'b1; rsv_addr = 5'd7;
      cycle();
      rsv_valid = 1'b0;
      set_req(0, 1'b1, 5'd7, 32'h0000_0077);
      cycle();
      set_req(0, 1'b0, 5'd0, 32'd0);
      rsv_valid = 1'b1; rsv_addr = 5'd7;
      cycle();
      rsv_valid = 1'b0;
      vec++; if (busy[7] !== 1'b1) begin errs++; $display("FAIL sb_setwins got %b want 1", busy[7]); end
      vec++; if (busy !== m_busy) begin errs++; $display("FAIL sb_all got %h want %h", busy, m_busy); end
   endtask

   task automatic test_reserve_x0_wrap();
      enter_reset();
      leave_reset();
      rsv_valid = 1'b1; rsv_addr = 5'd0;
      cycle();
      rsv_valid = 1'b0;
      vec++; if (busy !== 32'd0) begin errs++; $display("FAIL rsv_x0 got %h want 0", busy); end
      set_req(1, 1'b1, 5'd3, 32'h0000_0333);
      #1;
      vec++; if (req_ready !== 2'b10) begin errs++; $display("FAIL wrap_ready got %b want 10", req_ready); end
      cycle();
      set_req(0, 1'b1, 5'd4, 32'h0000_0444);
      #1;
      vec++; if (req_ready !== 2'b01) begin errs++; $display("FAIL wrap_ptr got %b want 01", req_ready); end
      set_req(0, 1'b0, 5'd0, 32'd0);
      set_req(1, 1'b0, 5'd0, 32'd0);
      cycle();
   endtask

   task automatic test_random();
      logic [N-1:0] g;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i] || g[i] || c == 0)
               set_req(i, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
         rsv_valid = ($urandom_range(0, 2) == 0);
         rsv_addr = 5'($urandom_range(0, 31));
         #1;
         g = req_ready;
         vec++; if (req_ready !== exp_ready()) begin errs++; $display("FAIL rnd_ready[%0d] got %b want %b", c, req_ready, exp_ready()); end
         cycle();
         vec++; if (regwen !== m_regwen || waddr !== m_waddr || wdata !== m_wdata) begin
            errs++; $display("FAIL rnd_write[%0d] got %b/%0d/%h want %b/%0d/%h", c, regwen, waddr, wdata, m_regwen, m_waddr, m_wdata);
         end
         vec++; if (busy !== m_busy) begin errs++; $display("FAIL rnd_busy[%0d] got %h want %h", c, busy, m_busy); end
      end
      req_valid = '0;
      rsv_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_mid_write();
      test_contention();
      test_x0();
      test_scoreboard();
      test_reserve_x0_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
